reg_wb_scoreboard: RTL and testbench

- Tracks in-flight register writebacks between issue and writeback in the RV32 pipeline.
- Stalls issue on RAW hazards and on write-after-write (WAW) counter saturation.
- Consumes the decoded write enable and destination register (rd) of each instruction at issue, and the writeback port's valid/address at completion.
- Sits beside the issue stage; its ready output gates instruction issue.

---
 rtl/reg_wb_scoreboard.sv | 118 +++++++++++
 tb/tb_reg_wb_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_scoreboard.sv
// Register writeback scoreboard: per-register pending-write counters that gate issue on RAW/WAW hazards.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hazards before they reach issue_ready.
module reg_wb_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [4:0]             issue_rs1,
  input  logic                   issue_rs1_used,
  input  logic [4:0]             issue_rs2,
  input  logic                   issue_rs2_used,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_rd_wen,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   wb_underflow
);

  localparam logic [CNT_W-1:0]       PEND_MAX  = '1;
  localparam logic [CNT_W-1:0]       PEND_ONE  = CNT_W'(1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  logic [CNT_W-1:0]       pend_r [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_count_r;
  logic                   wb_underflow_r;

  logic [CNT_W-1:0]    rs1_pend_s, rs2_pend_s, rd_pend_s, wb_pend_s;
  logic                raw_s, waw_full_s, ready_s, fire_s, underflow_set_s;
  logic [NUM_REGS-1:0] inc_s, dec_s, busy_s;

  // Index 0 and indices beyond NUM_REGS read as an idle register.
  function automatic logic [CNT_W-1:0] pend_of(input logic [4:0] idx);
    logic [CNT_W-1:0] p;
    p = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      p = (idx == 5'(r)) ? pend_r[r] : p;
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] hazard_pend(input logic [4:0] idx);
    logic [CNT_W-1:0] p;
    p = pend_of(idx);
`ifdef SCOREBOARD_WB_BYPASS_EN
    p = (wb_valid && wb_rd == idx && idx != 5'd0 && p != '0) ? p - PEND_ONE : p;
`endif
    return p;
  endfunction

  // Hazard detection and issue handshake.
  always_comb begin
    wb_pend_s  = pend_of(wb_rd);
    rs1_pend_s = hazard_pend(issue_rs1);
    rs2_pend_s = hazard_pend(issue_rs2);
    rd_pend_s  = hazard_pend(issue_rd);
    raw_s      = (issue_rs1_used && issue_rs1 != 5'd0 && rs1_pend_s != '0) ||
                 (issue_rs2_used && issue_rs2 != 5'd0 && rs2_pend_s != '0);
    waw_full_s = issue_rd_wen && issue_rd != 5'd0 && rd_pend_s == PEND_MAX;
    ready_s    = !raw_s && !waw_full_s && !flush;
    fire_s     = issue_valid && ready_s;
    underflow_set_s = wb_valid && wb_rd != 5'd0 && wb_pend_s == '0 && !flush;
  end

  // Per-register increment/decrement requests and busy decode.
  always_comb begin
    inc_s  = '0;
    dec_s  = '0;
    busy_s = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_s[r]  = fire_s && issue_rd_wen && issue_rd == 5'(r);
      dec_s[r]  = wb_valid && wb_rd == 5'(r) && pend_r[r] != '0;
      busy_s[r] = pend_r[r] != '0;
    end
  end

  // Pending-write counters; flush wins over issue and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_r[r] <= '0;
    end else begin
      pend_r[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (flush)                     pend_r[r] <= '0;
        else if (inc_s[r] && !dec_s[r]) pend_r[r] <= pend_r[r] + PEND_ONE;
        else if (dec_s[r] && !inc_s[r]) pend_r[r] <= pend_r[r] - PEND_ONE;
        else                           pend_r[r] <= pend_r[r];
      end
    end
  end

  // Saturating stall counter and sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r  <= '0;
      wb_underflow_r <= 1'b0;
    end else begin
      if (issue_valid && !ready_s && stall_count_r != STALL_MAX)
        stall_count_r <= stall_count_r + STALL_ONE;
      else
        stall_count_r <= stall_count_r;
      wb_underflow_r <= wb_underflow_r || underflow_set_s;
    end
  end

  assign issue_ready  = ready_s;
  assign busy_vec     = busy_s;
  assign stall_count  = stall_count_r;
  assign wb_underflow = wb_underflow_r;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Self-checking bench for reg_wb_scoreboard: directed literal checks plus randomized traffic
// compared every cycle against a counter-array reference model.
module tb_reg_wb_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, issue_rd_wen = 1'b0;
  logic [4:0]  issue_rs1 = 5'd0, issue_rs2 = 5'd0, issue_rd = 5'd0, wb_rd = 5'd0;
  logic        wb_valid = 1'b0, flush = 1'b0;
  logic        issue_ready, wb_underflow;
  logic [31:0] busy_vec;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  int pend_m [32];
  int stall_m;
  bit uf_m;

  reg_wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .stall_count(stall_count), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pending count as seen by the hazard logic (optionally reduced by a same-cycle writeback).
  function automatic int seen_pend(input int r);
    int p;
    p = pend_m[r];
    if (BYP && wb_valid && int'(wb_rd) == r && r != 0 && p > 0) p = p - 1;
    return p;
  endfunction

  function automatic bit model_ready();
    bit raw, waw;
    raw = (issue_rs1_used && issue_rs1 != 5'd0 && seen_pend(issue_rs1) > 0) ||
          (issue_rs2_used && issue_rs2 != 5'd0 && seen_pend(issue_rs2) > 0);
    waw = issue_rd_wen && issue_rd != 5'd0 && seen_pend(issue_rd) == 3;
    return !raw && !waw && !flush;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int r = 1; r < 32; r++) b[r] = (pend_m[r] != 0);
    return b;
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
      stall_m = 0;
      uf_m = 1'b0;
    end else begin
      bit rdy;
      rdy = model_ready();
      if (issue_valid && !rdy && stall_m < 65535) stall_m = stall_m + 1;
      if (flush) begin
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
      end else begin
        bit dec;
        dec = wb_valid && wb_rd != 5'd0 && pend_m[wb_rd] > 0;
        if (wb_valid && wb_rd != 5'd0 && pend_m[wb_rd] == 0) uf_m = 1'b1;
        if (dec) pend_m[wb_rd] = pend_m[wb_rd] - 1;
        if (issue_valid && rdy && issue_rd_wen && issue_rd != 5'd0)
          pend_m[issue_rd] = pend_m[issue_rd] + 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("ready", {31'd0, issue_ready}, {31'd0, model_ready()});
    chk("busy", busy_vec, model_busy());
    chk("stall", {16'd0, stall_count}, stall_m);
    chk("uflow", {31'd0, wb_underflow}, {31'd0, uf_m});
  end

  task automatic drive(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                       input bit u2, input bit [4:0] rd, input bit wen, input bit wv,
                       input bit [4:0] wr, input bit fl);
    issue_valid = v; issue_rs1 = r1; issue_rs1_used = u1; issue_rs2 = r2; issue_rs2_used = u2;
    issue_rd = rd; issue_rd_wen = wen; wb_valid = wv; wb_rd = wr; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) tick();
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    tick();

    // Issue x5, then a reader of x5 stalls until writeback retires it.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("iss5_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk("busy5", busy_vec, 32'h0000_0020);
    chk("raw5_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clk);
    chk("stall1", {16'd0, stall_count}, 32'd1);
    chk("wb5_ready", {31'd0, issue_ready}, {31'd0, BYP});
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("after_wb5_ready", {31'd0, issue_ready}, 32'd1);
    chk("after_wb5_busy", busy_vec, 32'h0);
    chk("stall2", {16'd0, stall_count}, BYP ? 32'd1 : 32'd2);
    tick();

    // Saturate x7 and check the WAW limit.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
      @(negedge clk); chk("iss7_ready", {31'd0, issue_ready}, 32'd1);
      tick();
    end
    @(negedge clk); chk("waw7_full", {31'd0, issue_ready}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0);
    @(negedge clk); chk("iss_wb7_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("pend7_is2", {31'd0, issue_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk); chk("pend7_full_again", {31'd0, issue_ready}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    repeat (3) tick();
    idle();
    @(negedge clk); chk("x7_drained", busy_vec, 32'h0);
    tick();

    // x0 is never tracked.
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk); chk("x0_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    @(negedge clk);
    chk("x0_busy", busy_vec, 32'h0);
    chk("x0_uflow", {31'd0, wb_underflow}, 32'd0);
    tick();

    // Underflow on x9 is sticky.
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("uflow_set", {31'd0, wb_underflow}, 32'd1);
    chk("uflow_busy", busy_vec, 32'h0);
    repeat (3) tick();
    @(negedge clk); chk("uflow_sticky", {31'd0, wb_underflow}, 32'd1);

    // Flush clears pending writes and blocks the same-cycle issue.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    issue_rd = 5'd4;
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    chk("pre_flush_busy", busy_vec, 32'h0000_0018);
    chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    idle();
    @(negedge clk); chk("post_flush_busy", busy_vec, 32'h0);
    tick();

    // Reset asserted in the middle of a stall clears the counter immediately.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_mid_busy", busy_vec, 32'h0);
    chk("rst_mid_uflow", {31'd0, wb_underflow}, 32'd0);
    idle();
    tick();
    rst_n = 1'b1;

    // Randomized traffic on a small register window to force hazards.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
      end
      issue_valid    = ($urandom_range(0, 9) < 7);
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs1_used = 1'($urandom_range(0, 1));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rs2_used = 1'($urandom_range(0, 1));
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rd_wen   = ($urandom_range(0, 3) != 0);
      wb_valid       = ($urandom_range(0, 9) < 4);
      wb_rd          = 5'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 39) == 0);
      tick();
    end

    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
